// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide execute unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  // operand_b selects which source operand the signedness question is about
  function automatic logic is_signed(muldiv_op_e op, logic operand_b);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      OP_MULHSU:               return !operand_b;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
module muldiv_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            start,
  input  logic            abort,
  input  logic            div_mode,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [CW-1:0]   count_reg;
  logic            run_reg;
  logic            div_reg;
  logic [XLEN-1:0] hi_reg;
  logic [XLEN-1:0] lo_reg;
  logic [XLEN-1:0] operand_reg;

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;

  // hi holds partial product / remainder, lo holds multiplier / quotient bits
  always_comb begin
    add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, operand_reg} : '0);
    shifted = {hi_reg, lo_reg[XLEN-1]};
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (div_reg) begin
      if (shifted >= {1'b0, operand_reg}) begin
        hi_next = XLEN'(shifted - {1'b0, operand_reg});
        lo_next = {lo_reg[XLEN-2:0], 1'b1};
      end else begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo_reg[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {add_sum, lo_reg[XLEN-1:1]};
    end
  end

  assign done = run_reg && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg   <= '0;
      run_reg     <= 1'b0;
      div_reg     <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      operand_reg <= '0;
    end else if (abort) begin
      count_reg <= '0;
      run_reg   <= 1'b0;
    end else if (start) begin
      count_reg   <= '0;
      run_reg     <= 1'b1;
      div_reg     <= div_mode;
      hi_reg      <= '0;
      lo_reg      <= div_mode ? op_a : op_b;
      operand_reg <= div_mode ? op_b : op_a;
    end else if (run_reg) begin
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      count_reg <= done ? '0 : count_reg + 1'b1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_muldiv_stage.sv
// RV32M execute unit: handshake FSM, special-case shortcuts and sign fixup around the iterative core.
module execute_muldiv_stage
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            EXECUTE_CLOCK,
  input  logic            EXECUTE_RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [2:0]      IN_OP,
  input  logic [XLEN-1:0] IN_A,
  input  logic [XLEN-1:0] IN_B,
  input  logic [RD_W-1:0] IN_RD,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_RESULT,
  output logic [RD_W-1:0] OUT_RD,
  output logic            BUSY
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_reg;
  muldiv_op_e      op_reg;
  logic            neg_reg;
  logic [RD_W-1:0] rd_reg;
  logic [XLEN-1:0] result_reg;
  logic            out_valid_reg;

  muldiv_op_e      op_in;
  logic            a_neg, b_neg, result_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] special_result;
  logic            accept;

  logic            core_done;
  logic [XLEN-1:0] core_hi, core_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    op_in    = muldiv_op_e'(IN_OP);
    a_neg    = is_signed(op_in, 1'b0) && IN_A[XLEN-1];
    b_neg    = is_signed(op_in, 1'b1) && IN_B[XLEN-1];
    mag_a    = a_neg ? -IN_A : IN_A;
    mag_b    = b_neg ? -IN_B : IN_B;
    // remainder follows the dividend; everything else is the xor of operand signs
    result_neg = (op_in == OP_REM || op_in == OP_REMU) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(op_in) && (IN_B == '0);
    overflow = (op_in == OP_DIV || op_in == OP_REM) && (IN_A == MOST_NEG) && (IN_B == '1);
    special  = div_zero || overflow;
    special_result = '0;
    if (div_zero)
      special_result = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : IN_A;
    else if (overflow)
      special_result = (op_in == OP_DIV) ? IN_A : '0;
    accept = IN_VALID && (state_reg == IDLE) && !FLUSH;
  end

  muldiv_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (EXECUTE_CLOCK),
    .srst     (EXECUTE_RESET),
    .start    (accept && !special),
    .abort    (FLUSH),
    .div_mode (is_div(op_in)),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .done     (core_done),
    .hi_next  (core_hi),
    .lo_next  (core_lo)
  );

  // final iteration feeds straight into the sign fixup so DONE is entered on the last step
  always_comb begin
    prod_fix = neg_reg ? -{core_hi, core_lo} : {core_hi, core_lo};
    case (op_reg)
      OP_MUL:                      fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_result = neg_reg ? -core_lo : core_lo;
      default:                     fix_result = neg_reg ? -core_hi : core_hi;
    endcase
  end

  always_ff @(posedge EXECUTE_CLOCK) begin
    if (EXECUTE_RESET) begin
      state_reg     <= IDLE;
      op_reg        <= OP_MUL;
      neg_reg       <= 1'b0;
      rd_reg        <= '0;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (FLUSH) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (IN_VALID) begin
          op_reg  <= op_in;
          rd_reg  <= IN_RD;
          neg_reg <= result_neg;
          if (special) begin
            result_reg    <= special_result;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: if (core_done) begin
          result_reg    <= fix_result;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
        end
        DONE: if (OUT_READY) begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign IN_READY   = (state_reg == IDLE);
  assign BUSY       = (state_reg != IDLE);
  assign OUT_VALID  = out_valid_reg;
  assign OUT_RESULT = result_reg;
  assign OUT_RD     = rd_reg;

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Directed-vector bench for execute_muldiv_stage with hand-computed RV32M results.
module tb_execute_muldiv_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  int assertions = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_muldiv_stage #(.XLEN(32), .RD_W(5)) dut (
    .EXECUTE_CLOCK (clk),
    .EXECUTE_RESET (rst),
    .IN_VALID      (in_valid),
    .IN_READY      (in_ready),
    .IN_OP         (in_op),
    .IN_A          (in_a),
    .IN_B          (in_b),
    .IN_RD         (in_rd),
    .FLUSH         (flush),
    .OUT_VALID     (out_valid),
    .OUT_READY     (out_ready),
    .OUT_RESULT    (out_result),
    .OUT_RD        (out_rd),
    .BUSY          (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one op, measure accept-to-valid latency, optionally stall, then complete the handshake.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                        input int hold);
    int lat;
    @(negedge clk);
    check_eq("ready_before", in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0; in_a = '0; in_b = '0; in_rd = '0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("latency", lat, exp_lat);
    check_eq("result", out_result, exp);
    check_eq("rd", out_rd, rd);
    check_eq("ready_in_done", in_ready, 0);
    check_eq("busy_in_done", busy, 1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check_eq("hold_result", out_result, exp);
      check_eq("hold_rd", out_rd, rd);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_ready", in_ready, 0);
    end
    $display("op=%0d a=%h b=%h rd=%0d -> result=%h lat=%0d hold=%0d", op, a, b, rd, out_result, lat, hold);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("valid_after_hs", out_valid, 0);
    check_eq("ready_after_hs", in_ready, 1);
  endtask

  // Start a long divide, then kill it with FLUSH or reset after n RUN cycles.
  task automatic abort_op(input logic use_reset, input int n);
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'h1234_5678; in_b = 32'd7; in_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
    if (use_reset) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check_eq(use_reset ? "rst_valid" : "flush_valid", out_valid, 0);
    check_eq(use_reset ? "rst_ready" : "flush_ready", in_ready, 1);
    check_eq(use_reset ? "rst_busy" : "flush_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq(use_reset ? "rst_no_output" : "flush_no_output", seen, 0);
    $display("abort via %s at RUN cycle %0d", use_reset ? "reset" : "flush", n);
    run_op(3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 33, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_rd", out_rd, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 1);

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000, 33, 0);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, 33, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd13, 32'hFFFF_FFFF, 33, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd14, 32'hFFFF_FFFD, 33, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFF, 33, 0);
    run_op(3'd5, 32'd100,       32'd7,         5'd16, 32'd14,        33, 0);
    run_op(3'd7, 32'd100,       32'd7,         5'd17, 32'd2,         33, 0);
    run_op(3'd4, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1,  0);
    run_op(3'd6, 32'd5,         32'd0,         5'd19, 32'd5,         1,  0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1,  0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,         1,  0);
    run_op(3'd5, 32'd100,       32'd7,         5'd22, 32'd14,        33, 10);

    abort_op(1'b0, 12);
    abort_op(1'b1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
